// File: rtl/display_ndigit.sv
// display_ndigit: time-multiplexed N-digit seven-segment driver with tear-free frame shadowing.
// Define SEGDISP_DIM_EN to enable PWM dimming from the captured bright_in level.
module display_ndigit #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIGIT_CYCLES = 8192
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_DIGITS*5-1:0] data_in,
  input  logic                    mode_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [3:0]              bright_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   strobe_out,
  output logic                    frame_out
);

  localparam int unsigned SlotW = $clog2(DIGIT_CYCLES);
  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);

  localparam logic [SlotW-1:0] SlotLast = SlotW'(DIGIT_CYCLES - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);
  localparam logic [6:0]       SegDark  = 7'h7F;

  // Hex glyphs, active-low gfedcba.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    g = SegDark;
    unique case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Alpha glyphs: code n is the n-th letter; 0 and codes above 26 are blank.
  function automatic logic [6:0] alpha_glyph(input logic [4:0] code);
    logic [6:0] g;
    g = SegDark;
    case (code)
      5'd1:    g = 7'h08; // A
      5'd2:    g = 7'h03; // b
      5'd3:    g = 7'h46; // C
      5'd4:    g = 7'h21; // d
      5'd5:    g = 7'h06; // E
      5'd6:    g = 7'h0E; // F
      5'd7:    g = 7'h42; // G
      5'd8:    g = 7'h09; // H
      5'd9:    g = 7'h79; // I
      5'd10:   g = 7'h61; // J
      5'd11:   g = 7'h0A; // K
      5'd12:   g = 7'h47; // L
      5'd13:   g = 7'h6A; // M
      5'd14:   g = 7'h2B; // n
      5'd15:   g = 7'h40; // O
      5'd16:   g = 7'h0C; // P
      5'd17:   g = 7'h18; // q
      5'd18:   g = 7'h2F; // r
      5'd19:   g = 7'h12; // S
      5'd20:   g = 7'h07; // t
      5'd21:   g = 7'h41; // U
      5'd22:   g = 7'h63; // v
      5'd23:   g = 7'h55; // W
      5'd24:   g = 7'h09; // X
      5'd25:   g = 7'h11; // y
      5'd26:   g = 7'h24; // Z
      default: g = SegDark;
    endcase
    return g;
  endfunction

  // Slot and digit counters
  logic [SlotW-1:0] slot_q, slot_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             slot_wrap;
  logic             frame_wrap;

  assign slot_wrap  = (slot_q == SlotLast);
  assign frame_wrap = slot_wrap && (idx_q == IdxLast);

  always_comb begin
    slot_d = slot_q + SlotW'(1);
    idx_d  = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
    end
  end

  // Shadow registers, loaded only at the frame boundary so a frame never tears.
  logic [NUM_DIGITS*5-1:0] data_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic                    mode_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_q  <= '0;
      blank_q <= '1;
      dp_q    <= '0;
      mode_q  <= 1'b0;
    end else if (frame_wrap) begin
      data_q  <= data_in;
      blank_q <= blank_in;
      dp_q    <= dp_in;
      mode_q  <= mode_in;
    end
  end

  logic pwm_on;

`ifdef SEGDISP_DIM_EN
  logic [3:0] bright_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bright_q <= 4'hF;
    end else if (frame_wrap) begin
      bright_q <= bright_in;
    end
  end

  assign pwm_on = (slot_q[SlotW-1 -: 4] <= bright_q);
`else
  logic unused_bright;
  assign unused_bright = ^bright_in;
  assign pwm_on        = 1'b1;
`endif

  // Per-digit views; digit 0 lives in the most significant field of each vector.
  logic [4:0] code_arr  [NUM_DIGITS];
  logic       blank_arr [NUM_DIGITS];
  logic       dp_arr    [NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign code_arr[i]  = data_q[(NUM_DIGITS-1-i)*5 +: 5];
    assign blank_arr[i] = blank_q[NUM_DIGITS-1-i];
    assign dp_arr[i]    = dp_q[NUM_DIGITS-1-i];
  end

  logic [4:0]            cur_code;
  logic [6:0]            cur_glyph;
  logic                  lit;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] strobe_d;

  assign cur_code  = code_arr[idx_q];
  assign cur_glyph = mode_q ? alpha_glyph(cur_code) : hex_glyph(cur_code[3:0]);

  // A blank glyph leaves the digit fully dark; the last slot clock is a ghosting guard.
  assign lit = !blank_arr[idx_q] && pwm_on && !slot_wrap && (cur_glyph != SegDark);

  always_comb begin
    seg_d    = SegDark;
    dp_d     = 1'b1;
    strobe_d = '1;
    if (lit) begin
      seg_d                    = cur_glyph;
      dp_d                     = !dp_arr[idx_q];
      strobe_d[IdxLast - idx_q] = 1'b0;
    end
  end

  logic [6:0]            seg_q;
  logic                  dp_out_q;
  logic [NUM_DIGITS-1:0] strobe_q;
  logic                  frame_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      seg_q    <= SegDark;
      dp_out_q <= 1'b1;
      strobe_q <= '1;
      frame_q  <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      dp_out_q <= dp_d;
      strobe_q <= strobe_d;
      frame_q  <= frame_wrap;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_out_q;
  assign strobe_out = strobe_q;
  assign frame_out  = frame_q;

endmodule

// File: tb/tb_display_ndigit.sv
// tb_display_ndigit: scoreboard bench; a time-based reference model predicts every output cycle.
module tb_display_ndigit;

  localparam int N  = 4;
  localparam int D  = 16;
  localparam int ND = N * D;

  logic           clk_in = 1'b0;
  logic           rst_in = 1'b0;
  logic [N*5-1:0] data_in = '0;
  logic           mode_in = 1'b0;
  logic [N-1:0]   blank_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [3:0]     bright_in = 4'hF;
  logic [6:0]     seg_out;
  logic           dp_out;
  logic [N-1:0]   strobe_out;
  logic           frame_out;

  display_ndigit #(
    .NUM_DIGITS  (N),
    .DIGIT_CYCLES(D)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .mode_in   (mode_in),
    .blank_in  (blank_in),
    .dp_in     (dp_in),
    .bright_in (bright_in),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .strobe_out(strobe_out),
    .frame_out (frame_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] strobe;
    logic         frame;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int   alpha_set[15] = '{0, 3, 5, 10, 12, 15, 18, 19, 21, 24, 27, 28, 29, 30, 31};

  function automatic logic [6:0] ref_glyph(input bit mode, input int code);
    if (!mode) begin
      case (code % 16)
        0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
        4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
        8: return 7'h00;   9: return 7'h10;   10: return 7'h08;  11: return 7'h03;
        12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
      endcase
    end
    case (code)
      3: return 7'h46;   5: return 7'h06;   10: return 7'h61;  12: return 7'h47;
      15: return 7'h40;  18: return 7'h2F;  19: return 7'h12;  21: return 7'h41;
      24: return 7'h09;  default: return 7'h7F;
    endcase
  endfunction

  // Reference model: position in time since reset release decides digit, slot and frame.
  longint k;
  bit     fr_valid;
  int     fr_code[N];
  bit     fr_blank[N];
  bit     fr_dp[N];
  bit     fr_mode;
  int     fr_bright;

  always @(posedge clk_in) begin
    exp_t   e;
    longint p;
    int     slot, dig;
    bit     gate;
    logic [6:0] g;
    e = '{seg: 7'h7F, dp: 1'b1, strobe: '1, frame: 1'b0};
    if (!rst_in) begin
      k        = 0;
      fr_valid = 0;
    end else begin
      k++;
      p    = k - 1;
      slot = int'(p % D);
      dig  = int'((p / D) % N);
`ifdef SEGDISP_DIM_EN
      gate = ((slot * 16) / D) <= fr_bright;
`else
      gate = 1'b1;
`endif
      if (fr_valid && !fr_blank[dig] && slot != D - 1 && gate) begin
        g = ref_glyph(fr_mode, fr_code[dig]);
        if (g != 7'h7F) begin
          e.seg    = g;
          e.dp     = !fr_dp[dig];
          e.strobe = ~(N'(1) << (N - 1 - dig));
        end
      end
      e.frame = (k % ND == 0);
      if (k % ND == 0) begin
        fr_valid = 1;
        for (int i = 0; i < N; i++) begin
          fr_code[i]  = int'((data_in >> ((N - 1 - i) * 5)) & 20'h1F);
          fr_blank[i] = blank_in[N - 1 - i];
          fr_dp[i]    = dp_in[N - 1 - i];
        end
        fr_mode   = mode_in;
        fr_bright = int'(bright_in);
      end
    end
    exp_q.push_back(e);
  end

  // Monitor: pops one prediction per cycle; while reset is held the reset state is required.
  always @(negedge clk_in) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst_in) e = '{seg: 7'h7F, dp: 1'b1, strobe: '1, frame: 1'b0};
      total++;
      if (seg_out !== e.seg || dp_out !== e.dp || strobe_out !== e.strobe ||
          frame_out !== e.frame) begin
        bad++;
        $display("FAIL outputs t=%0t got seg=%h dp=%b strobe=%b frame=%b want seg=%h dp=%b strobe=%b frame=%b",
                 $time, seg_out, dp_out, strobe_out, frame_out, e.seg, e.dp, e.strobe, e.frame);
      end
    end
  end

  task automatic set_codes(input int c0, input int c1, input int c2, input int c3);
    data_in = {5'(c0), 5'(c1), 5'(c2), 5'(c3)};
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  task automatic random_phase();
    mode_in = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) begin
      if (mode_in) data_in[i*5 +: 5] = 5'(alpha_set[$urandom_range(0, 14)]);
      else         data_in[i*5 +: 5] = 5'($urandom_range(0, 31));
    end
    blank_in  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
    dp_in     = N'($urandom);
    bright_in = 4'($urandom);
    cycles($urandom_range(20, 150));
  endtask

  initial begin
    int cnt;
    bit lit_seen;
    bit found;

    mode_in = 1'b0;
    set_codes(1, 2, 3, 4);
    cycles(3);
    #1 rst_in = 1'b1;

    // Dark first frame, then 1 2 3 4; switch to F mid-frame 1.
    cycles(64 + 20);
    set_codes(15, 15, 15, 15);
    cycles(100);

    mode_in = 1'b1;
    set_codes(5, 18, 18, 31);
    cycles(2 * ND);

    mode_in = 1'b0;
    set_codes(8, 8, 8, 8);
    dp_in = 4'b0100;
    cycles(2 * ND);

    bright_in = 4'd3;
    dp_in     = '0;
    set_codes(1, 2, 3, 4);
    cycles(2 * ND);

    for (int r = 0; r < 6; r++) random_phase();

    // Mid-frame reset during digit 2.
    mode_in   = 1'b0;
    blank_in  = '0;
    bright_in = 4'hF;
    set_codes(9, 10, 11, 12);
    cycles(2 * ND);
    found = 0;
    for (int i = 0; i < 4 * ND && !found; i++) begin
      @(negedge clk_in);
      if (strobe_out == 4'b1101) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL digit2_seen got strobe=%b want 1101 within budget", strobe_out);
    end
    #2 rst_in = 1'b0;
    #1;
    total++;
    if (strobe_out !== 4'hF || seg_out !== 7'h7F) begin
      bad++;
      $display("FAIL async_reset got strobe=%b seg=%h want strobe=1111 seg=7f",
               strobe_out, seg_out);
    end
    cycles(3);
    rst_in = 1'b1;
    cnt = 0;
    lit_seen = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_in);
      cnt++;
      if (strobe_out != 4'hF) lit_seen = 1;
      if (frame_out) found = 1;
    end
    total++;
    if (!found || cnt != ND || lit_seen) begin
      bad++;
      $display("FAIL first_frame got clocks=%0d lit=%0d want clocks=%0d lit=0",
               cnt, lit_seen, ND);
    end
    cycles(2 * ND);
    random_phase();
    random_phase();

    cycles(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
